// File: rtl/onehot_scan_tracker.sv
// Tracks a 4-bit walking one-hot scan bus: decodes position and direction, counts laps, flags protocol violations.
// Registered outputs respond one cycle after a valid sample; no backpressure, valid=0 freezes everything.
module onehot_scan_tracker #(
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [3:0]       pat,
  input  logic             clear_err,
  output logic [1:0]       idx,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic             lap_tick,
  output logic [LAP_W-1:0] lap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_GAP   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [LAP_W-1:0] LAP_ONE = {{(LAP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             exit_top_q, exit_top_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             lap_tick_q, lap_tick_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;

  logic       pat_zero;
  logic       pat_hot;
  logic [1:0] pat_k;
  logic       step_up;
  logic       step_dn;

  always_comb begin
    pat_zero = (pat == 4'b0000);
    pat_hot  = 1'b1;
    pat_k    = 2'd0;
    case (pat)
      4'b0001: pat_k = 2'd0;
      4'b0010: pat_k = 2'd1;
      4'b0100: pat_k = 2'd2;
      4'b1000: pat_k = 2'd3;
      default: pat_hot = 1'b0;
    endcase
  end

  // 3-bit compare so idx=3 cannot alias a step up onto 0 (and vice versa)
  assign step_up = ({1'b0, pat_k} == ({1'b0, idx_q} + 3'd1));
  assign step_dn = (({1'b0, pat_k} + 3'd1) == {1'b0, idx_q});

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    exit_top_d = exit_top_q;
    lap_cnt_d  = lap_cnt_q;
    lap_tick_d = 1'b0;

    if (clear_err) begin
      state_d = ST_IDLE;
    end else if (valid && (state_q != ST_ERR)) begin
      if (!pat_zero && !pat_hot) begin
        state_d = ST_ERR;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pat_hot) begin
              state_d = ST_TRACK;
              idx_d   = pat_k;
              if (pat_k == 2'd0) dir_d = 1'b1;
              else if (pat_k == 2'd3) dir_d = 1'b0;
            end
          end
          ST_TRACK: begin
            if (pat_zero) begin
              if (idx_q == 2'd3) begin
                state_d    = ST_GAP;
                exit_top_d = 1'b1;
              end else if (idx_q == 2'd0) begin
                state_d    = ST_GAP;
                exit_top_d = 1'b0;
              end else begin
                state_d = ST_ERR;
              end
            end else if (pat_k == idx_q) begin
              state_d = ST_TRACK;
            end else if (step_up) begin
              idx_d = pat_k;
              dir_d = 1'b1;
            end else if (step_dn) begin
              idx_d = pat_k;
              dir_d = 1'b0;
            end else begin
              state_d = ST_ERR;
            end
          end
          ST_GAP: begin
            if (pat_zero) begin
              state_d = ST_GAP;
            end else if (pat_k == 2'd0) begin
              state_d = ST_TRACK;
              idx_d   = 2'd0;
              dir_d   = 1'b1;
              if (exit_top_q) begin
                lap_cnt_d  = lap_cnt_q + LAP_ONE;
                lap_tick_d = 1'b1;
              end
            end else if (pat_k == 2'd3) begin
              state_d = ST_TRACK;
              idx_d   = 2'd3;
              dir_d   = 1'b0;
              if (!exit_top_q) begin
                lap_cnt_d  = lap_cnt_q + LAP_ONE;
                lap_tick_d = 1'b1;
              end
            end else begin
              // a middle position cannot follow a gap: the scan left from an edge
              state_d = ST_ERR;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end

    locked_d = (state_d == ST_TRACK) || (state_d == ST_GAP);
    err_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      dir_q      <= 1'b1;
      exit_top_q <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      lap_tick_q <= 1'b0;
      lap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      exit_top_q <= exit_top_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      lap_tick_q <= lap_tick_d;
      lap_cnt_q  <= lap_cnt_d;
    end
  end

  assign idx      = idx_q;
  assign dir      = dir_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign lap_tick = lap_tick_q;
  assign lap_cnt  = lap_cnt_q;

endmodule

// File: doc/onehot_scan_tracker.md
Name: onehot_scan_tracker

Overview:
- Monitors a 4-bit walking one-hot scan bus, such as the digit/group select driven by the bidirectional shifter, from the consuming side.
- Decodes the active position and infers the shift direction.
- Counts completed laps and flags any pattern or transition that the shifter protocol cannot produce.
- Sits between the scan driver and the display/debug logic; used for self-check and for indexing per-group data.

Parameters:
- LAP_W, 8, width of the lap counter; wraps modulo 2^LAP_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  sample strobe; pat is evaluated only on cycles where valid=1.
- pat  input  4  observed scan pattern.
- clear_err  input  1  one-cycle pulse; leaves ERR and returns to IDLE.
- idx  output  2  position of the last legal one-hot bit (0 = bit0).
- dir  output  1  1 = shifting left (toward bit3), 0 = shifting right.
- locked  output  1  high in TRACK or GAP.
- err  output  1  sticky protocol-violation flag.
- lap_tick  output  1  one-cycle pulse on each lap increment.
- lap_cnt  output  LAP_W  completed-lap count.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, dir=1, locked=0, err=0, lap_tick=0, lap_cnt=0.
- All outputs are registered. The response to a sample appears on the clock edge that samples valid=1, so it is visible in the following cycle.
- lap_tick is low on every cycle that does not increment lap_cnt.
- valid=0: state and all outputs hold; lap_tick=0.

Legal patterns and transition classes:
- Legal patterns are 0000, 0001, 0010, 0100 and 1000.
- Any other value on a valid sample, in any state other than ERR, goes to ERR.
- Let i be the stored idx and k the index of a legal one-hot pat.
- Step up: k = i+1.
- Step down: k = i-1.
- Hold: pat equal to the previous one-hot value.
- Jump: |k-i| >= 2.

States:
- IDLE:
  - pat=0000: stay.
  - Any one-hot: go to TRACK with idx=k. Set dir=1 if pat=0001, dir=0 if pat=1000, otherwise keep dir.
- TRACK:
  - Step up: idx=k, dir=1.
  - Step down: idx=k, dir=0.
  - Hold: no change.
  - Jump: go to ERR.
  - pat=0000 with idx=3: go to GAP with exit edge = top.
  - pat=0000 with idx=0: go to GAP with exit edge = bottom.
  - pat=0000 with idx 1 or 2: go to ERR.
- GAP:
  - pat=0000: hold.
  - pat=0001: go to TRACK, idx=0, dir=1. If the exit edge was top, increment lap_cnt and pulse lap_tick.
  - pat=1000: go to TRACK, idx=3, dir=0. If the exit edge was bottom, increment lap_cnt and pulse lap_tick.
  - Re-entry at the opposite end (direction reversal during the gap) is legal but does not count a lap.
  - pat 0010 or 0100: go to ERR.
- ERR:
  - err=1, locked=0; idx, dir and lap_cnt hold.
  - valid samples are ignored.
  - Exit is only through clear_err or reset.

Common rules:
- clear_err in any state: next state IDLE, err=0, locked=0. idx, dir and lap_cnt are kept.
- clear_err and valid in the same cycle: clear_err wins and the sample is discarded.
- lap_cnt wraps from all-ones to 0, and lap_tick still pulses on that wrap.
- rst_n asserted in the middle of any state restores all reset values immediately (asynchronously).

Test Plan:
1. Reset, then valid every cycle with pat = 0001, 0010, 0100, 1000, 0000, 0001 -> idx = 0,1,2,3,3,0; dir=1; locked=1 from the first sample; lap_cnt=1 with lap_tick high for exactly one cycle after the final 0001; err=0.
2. From idx=2 with dir=1, apply pat 0010, 0001, 0000, 1000 -> dir goes to 0 at the 0010 sample; GAP is entered with exit edge bottom; re-entry 1000 gives idx=3 and lap_cnt increments by 1. Then apply 0000 after reaching idx=3 by stepping up -> GAP; re-entry 1000 -> no lap increment.
3. Illegal values, each from a freshly cleared state: pat=0011 -> err=1, locked=0, idx holds. In TRACK at idx=0, pat=0100 (jump) -> err=1. In TRACK at idx=1, pat=0000 -> err=1. Subsequent valid samples leave err=1 and lap_cnt unchanged.
4. In ERR, assert clear_err together with valid and pat=0001 -> next cycle err=0 and state IDLE with locked=0. A following valid pat=0001 -> locked=1, idx=0.
5. With LAP_W=2, run 4 full left laps -> lap_cnt sequence 1,2,3,0 and lap_tick pulses four times. Toggle valid=0 during laps with pat held at garbage values such as 1111 -> no state change.
6. Mid-lap at idx=2 with lap_cnt=3, assert rst_n=0 asynchronously (not aligned to clk) -> all outputs return to reset values before the next clk edge.
